// File: rtl/fetch_queue_pkg.sv
// Shared fetch-side types and helpers for the fetch queue and decode.
// Holds the JAL opcode, the fetch packet layout and the J-type immediate.
package fetch_queue_pkg;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

    // Takes only inst[31:12]; the low bits play no part in the J immediate.
    function automatic logic [31:0] imm_j(input logic [31:12] hi);
        return {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Pointer FIFO of fetch packets; pointers carry a wrap bit.
// A flush clears it in one cycle, just like a reset.
module fetch_queue_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  fetch_pkt_t wdata,
    output fetch_pkt_t rdata,
    output logic       empty,
    output logic       full
);

    fetch_pkt_t       mem [DEPTH];
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;

    assign empty = (head == tail);
    assign full  = (head[PTR_W] != tail[PTR_W])
                && (head[PTR_W-1:0] == tail[PTR_W-1:0]);
    assign rdata = mem[head[PTR_W-1:0]];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset && !flush) mem[tail[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode packet queue with early JAL detection.
// A pushed JAL raises a registered one-cycle redirect back to fetch.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        redir_flush,
    output logic [31:0] redir_dnpc
);

    typedef enum logic {IDLE, PEND} redir_state_t;

    redir_state_t state;
    redir_state_t state_next;
    logic         redir_pending;
    logic         empty;
    logic         full;
    logic         push;
    logic         pop;
    logic         push_jal;
    fetch_pkt_t   wdata;
    fetch_pkt_t   rdata;

    assign redir_pending = (state == PEND);

    assign in_ready  = ~full & ~redir_pending & ~flush;
    assign out_valid = ~empty & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // push already excludes flush, so a JAL seen during flush never redirects
    assign push_jal  = push && (in_inst[6:0] == OPC_JAL);

    assign wdata.pc   = in_pc;
    assign wdata.inst = in_inst;
    assign out_pc     = rdata.pc;
    assign out_inst   = rdata.inst;

    fetch_queue_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        redir_flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (push_jal) state_next = PEND;
            end
            PEND: begin
                redir_flush = ~flush;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)         redir_dnpc <= '0;
        else if (push_jal) redir_dnpc <= in_pc + imm_j(in_inst[31:12]);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, streaming, JAL redirect,
// flush and mid-run reset, with hand-computed expected values.
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        redir_flush;
    logic [31:0] redir_dnpc;

    int vectors = 0;
    int errors  = 0;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL_P8  = 32'h0080_006F;
    localparam logic [31:0] JAL_M4  = 32'hFFDF_F06F;

    always #5 clock = ~clock;

    fetch_queue #(.DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .redir_flush (redir_flush),
        .redir_dnpc  (redir_dnpc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redir_flush", {31'd0, redir_flush}, 32'd0);
        chk("rst_redir_dnpc", redir_dnpc, 32'd0);

        // fill to DEPTH with decode stalled
        in_valid = 1'b1;
        in_inst  = NOP;
        for (int i = 0; i < 4; i++) begin
            in_pc = 32'h8000_0000 + 32'(4 * i);
            #1;
            chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        end
        #1;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head_pc", out_pc, 32'h8000_0000);
        // full queue still refuses a push while a pop happens
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_out_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
            tick();
        end
        chk("drained_out_valid", {31'd0, out_valid}, 32'd0);

        // streaming: one packet per cycle at occupancy one
        in_valid = 1'b1;
        in_inst  = NOP;
        in_pc    = 32'h0000_0100;
        #1;
        chk("lat_out_valid_T", {31'd0, out_valid}, 32'd0);
        tick();
        chk("lat_out_valid_T1", {31'd0, out_valid}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            in_pc = 32'h0000_0100 + 32'(4 * i);
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            chk("stream_out_pc", out_pc, 32'h0000_0100 + 32'(4 * (i - 1)));
            tick();
        end
        in_valid = 1'b0;
        chk("stream_last_pc", out_pc, 32'h0000_0110);
        tick();
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // JAL forward
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0010;
        in_inst   = JAL_P8;
        tick();
        in_valid = 1'b0;
        #1;
        chk("jalf_redir_flush", {31'd0, redir_flush}, 32'd1);
        chk("jalf_redir_dnpc", redir_dnpc, 32'h8000_0018);
        chk("jalf_in_ready", {31'd0, in_ready}, 32'd0);
        chk("jalf_out_inst", out_inst, JAL_P8);
        tick();
        chk("jalf_redir_one_cycle", {31'd0, redir_flush}, 32'd0);
        chk("jalf_in_ready_back", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("jalf_drained", {31'd0, out_valid}, 32'd0);

        // JAL backward, including wrap below zero
        in_valid = 1'b1;
        in_pc    = 32'h0000_0004;
        in_inst  = JAL_M4;
        tick();
        in_valid = 1'b0;
        #1;
        chk("jalb_redir_flush", {31'd0, redir_flush}, 32'd1);
        chk("jalb_redir_dnpc", redir_dnpc, 32'h0000_0000);
        tick();
        in_valid = 1'b1;
        in_pc    = 32'h0000_0000;
        tick();
        in_valid = 1'b0;
        #1;
        chk("jalw_redir_flush", {31'd0, redir_flush}, 32'd1);
        chk("jalw_redir_dnpc", redir_dnpc, 32'hFFFF_FFFC);
        chk("jalw_out_pc", out_pc, 32'h0000_0000);
        tick();
        tick();
        chk("jalw_drained", {31'd0, out_valid}, 32'd0);

        // flush with three entries and a redirect pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = NOP;
        in_pc     = 32'h8000_0000;
        tick();
        in_pc = 32'h8000_0004;
        tick();
        in_pc   = 32'h8000_0008;
        in_inst = JAL_P8;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("flush_redir_masked", {31'd0, redir_flush}, 32'd0);
        chk("flush_out_valid_masked", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready_masked", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_empty", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_no_redir", {31'd0, redir_flush}, 32'd0);

        // JAL offered during flush is neither queued nor redirected
        in_valid = 1'b1;
        in_pc    = 32'h8000_0020;
        in_inst  = JAL_P8;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flushpush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flushpush_redir", {31'd0, redir_flush}, 32'd0);
        chk("flushpush_in_ready", {31'd0, in_ready}, 32'd1);

        // reset mid-fill, with a JAL on the input at the reset edge
        in_valid = 1'b1;
        in_inst  = NOP;
        in_pc    = 32'h8000_0040;
        tick();
        in_pc = 32'h8000_0044;
        tick();
        in_pc   = 32'h8000_0048;
        in_inst = JAL_P8;
        reset   = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmid_redir", {31'd0, redir_flush}, 32'd0);
        chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rstmid_dnpc", redir_dnpc, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
